// File: rtl/qr_reconstructor_pkg.sv
// Shared definitions for the Q/R reconstructor: default widths, result-width
// derivation, counter-width derivation and the FSM state encoding.
package qr_reconstructor_pkg;

  localparam int WA_DEF = 3;
  localparam int WB_DEF = 2;
  localparam int WC_DEF = 3;

  // One extra bit over WA+WB absorbs the remainder added on top of the product.
  function automatic int calc_wr(input int wa, input int wb);
    return wa + wb + 1;
  endfunction

  function automatic int calc_cnt_w(input int wb);
    return $clog2(wb + 1);
  endfunction

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } state_t;

endpackage

// File: rtl/qr_reconstructor_ripple_adder.sv
// Unsigned W-bit ripple-carry adder built from full-adder cells; carry-in is 0
// and the final carry-out is dropped.
module qr_reconstructor_ripple_adder #(
  parameter int W = 6
) (
  input  logic [W-1:0] a_i,
  input  logic [W-1:0] b_i,
  output logic [W-1:0] sum_o
);

  logic [W-1:0] carry;

  assign carry[0] = 1'b0;

  for (genvar i = 0; i < W; i++) begin : g_fa
    assign sum_o[i] = a_i[i] ^ b_i[i] ^ carry[i];
    if (i < W - 1) begin : g_carry
      assign carry[i+1] = (a_i[i] & b_i[i]) | (carry[i] & (a_i[i] ^ b_i[i]));
    end
  end

endmodule

// File: rtl/qr_reconstructor.sv
// Radix-2 shift-add reconstructor: result = q_in * d_in + r_in, one divisor bit
// per clock. Define REM_CHECK_EN to add the rem_err invalid-remainder flag.
module qr_reconstructor
  import qr_reconstructor_pkg::*;
#(
  parameter  int WA = WA_DEF,
  parameter  int WB = WB_DEF,
  parameter  int WC = WC_DEF,
  localparam int WR = calc_wr(WA, WB)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic [WA-1:0] q_in,
  input  logic [WB-1:0] d_in,
  input  logic [WC-1:0] r_in,
  output logic          busy,
  output logic          done,
  output logic [WR-1:0] result
`ifdef REM_CHECK_EN
  ,
  output logic          rem_err
`endif
);

  localparam int CNT_W = calc_cnt_w(WB);

  state_t           state_q;
  logic [WR-1:0]    mreg_q;
  logic [WR-1:0]    acc_q;
  logic [WR-1:0]    acc_d;
  logic [WR-1:0]    sum;
  logic [WB-1:0]    breg_q;
  logic [CNT_W-1:0] cnt_q;
  logic             busy_q;
  logic             done_q;
  logic [WR-1:0]    result_q;

  qr_reconstructor_ripple_adder #(.W(WR)) u_adder (
    .a_i   (acc_q),
    .b_i   (mreg_q),
    .sum_o (sum)
  );

  // NOTE: combinational logic gets a value on every path so no latch is inferred.
  always_comb begin
    acc_d = acc_q;
    if (breg_q[0]) acc_d = sum;
  end

`ifdef REM_CHECK_EN
  logic rem_flag_q;
  logic rem_err_q;

  // A remainder not below the divisor, or any divide-by-zero, cannot come from a valid division.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rem_flag_q <= 1'b0;
      rem_err_q  <= 1'b0;
    end else if (state_q == IDLE && start) begin
      rem_flag_q <= ({{(WR-WC){1'b0}}, r_in} >= {{(WR-WB){1'b0}}, d_in}) || (d_in == '0);
    end else if (state_q == DONE) begin
      rem_err_q <= rem_flag_q;
    end
  end

  assign rem_err = rem_err_q;
`endif

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      mreg_q   <= '0;
      acc_q    <= '0;
      breg_q   <= '0;
      cnt_q    <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      result_q <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            mreg_q  <= {{(WR-WA){1'b0}}, q_in};
            breg_q  <= d_in;
            acc_q   <= {{(WR-WC){1'b0}}, r_in};
            cnt_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= RUN;
          end
        end
        RUN: begin
          acc_q  <= acc_d;
          mreg_q <= mreg_q << 1;
          breg_q <= breg_q >> 1;
          cnt_q  <= cnt_q + CNT_W'(1);
          if (cnt_q == CNT_W'(WB - 1)) state_q <= DONE;
        end
        DONE: begin
          done_q   <= 1'b1;
          result_q <= acc_q;
          busy_q   <= 1'b0;
          state_q  <= IDLE;
        end
        default: begin
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign busy   = busy_q;
  assign done   = done_q;
  assign result = result_q;

endmodule

// File: tb/tb_qr_reconstructor.sv
// Scoreboard bench for qr_reconstructor: expected result, rem flag and done
// edge are queued at acceptance and checked when done pulses.
module tb_qr_reconstructor;

  localparam int WA = 3;
  localparam int WB = 2;
  localparam int WC = 3;
  localparam int WR = WA + WB + 1;

  typedef struct {
    int unsigned res;
    bit          rem;
    int unsigned done_at;
  } exp_t;

  logic          clk;
  logic          rst_n;
  logic          start;
  logic [WA-1:0] q_in;
  logic [WB-1:0] d_in;
  logic [WC-1:0] r_in;
  logic          busy;
  logic          done;
  logic [WR-1:0] result;
`ifdef REM_CHECK_EN
  logic          rem_err;
`endif

  exp_t        sb[$];
  int unsigned cycle;
  int          n_checks;
  int          n_fails;
  logic        prev_done;

  qr_reconstructor dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .q_in   (q_in),
    .d_in   (d_in),
    .r_in   (r_in),
    .busy   (busy),
    .done   (done),
    .result (result)
`ifdef REM_CHECK_EN
    ,
    .rem_err(rem_err)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cycle <= cycle + 1;

  task automatic check(input string tag, input longint got, input longint exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cycle);
    end
  endtask

  // Monitor: every done pulse must match the oldest queued expectation.
  always @(negedge clk) begin
    if (done) begin
      exp_t e;
      check("done_gap", prev_done, 0);
      check("sb_nonempty", sb.size() > 0, 1);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        check("result", result, e.res);
        check("latency", cycle, e.done_at);
`ifdef REM_CHECK_EN
        check("rem_err", rem_err, e.rem);
`endif
      end
    end
    prev_done = done;
  end

  task automatic wait_idle();
    int n = 0;
    @(negedge clk);
    while (busy !== 1'b0 && n < 40) begin
      @(negedge clk);
      n++;
    end
    check("idle_wait", busy, 0);
  endtask

  // Drives one request on the first idle cycle and queues its expectation.
  task automatic issue(input int q, input int d, input int r, input bit keep);
    exp_t e;
    wait_idle();
    q_in  = q[WA-1:0];
    d_in  = d[WB-1:0];
    r_in  = r[WC-1:0];
    start = 1'b1;
    e.res     = q * d + r;
    e.rem     = (r >= d) || (d == 0);
    e.done_at = cycle + 1 + 3;
    sb.push_back(e);
    @(posedge clk);
    #1;
    if (!keep) start = 1'b0;
  endtask

  initial begin
    int busy_cnt;
    int n;
    cycle     = 0;
    n_checks  = 0;
    n_fails   = 0;
    prev_done = 1'b0;
    rst_n     = 1'b0;
    start     = 1'b0;
    q_in      = '0;
    d_in      = '0;
    r_in      = '0;

    repeat (3) @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_result", result, 0);
`ifdef REM_CHECK_EN
    check("rst_rem_err", rem_err, 0);
`endif
    rst_n = 1'b1;

    // Basic product, busy width
    issue(5, 3, 0, 1'b0);
    busy_cnt = 0;
    repeat (5) begin
      @(negedge clk);
      if (busy) busy_cnt++;
    end
    check("busy_cycles", busy_cnt, 3);

    // Maximum operands, then back-to-back
    issue(7, 3, 7, 1'b0);
    issue(3, 2, 1, 1'b0);

    // Zero divisor
    issue(6, 0, 5, 1'b0);

    // start held high, operands changed mid-run
    issue(5, 3, 0, 1'b1);
    q_in = 3'd1;
    d_in = 2'd1;
    r_in = 3'd1;
    issue(1, 1, 1, 1'b1);
    start = 1'b0;

    // Reset during RUN
    issue(7, 3, 2, 1'b0);
    @(negedge clk);
    rst_n = 1'b0;
    sb.delete();
    #1;
    check("abort_busy", busy, 0);
    check("abort_done", done, 0);
    check("abort_result", result, 0);
`ifdef REM_CHECK_EN
    check("abort_rem_err", rem_err, 0);
`endif
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    check("post_abort_result", result, 0);
    issue(4, 2, 1, 1'b0);

    // Remainder-validity cases
    issue(2, 2, 3, 1'b0);
    issue(2, 3, 1, 1'b0);

    // Random operands
    for (int i = 0; i < 6; i++) begin
      issue($urandom_range(0, 7), $urandom_range(0, 3), $urandom_range(0, 7), 1'b0);
    end

    n = 0;
    while (sb.size() > 0 && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("sb_drain", sb.size(), 0);
    check("final_busy", busy, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
